lsm_seq: RTL
============

# lsm_seq

Load/store-multiple sequencer for the MIPS pipeline. It consumes the held command and base address from the LSM pipeline register and expands the 16-bit register list into one word transfer per set bit. While busy it drives `remain_o`, which stalls the pipeline register. It optionally writes the final address back to the base register.

## Interface
- `CMD_W`, 21: command width.
- `LIST_W`, 16: register-list width.
- `ADDR_W`, 32: address and data width.

- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `cmd_valid_i` in 1: a command is present on `cmd_i`/`base_i`.
- `cmd_i` in 21: command fields.
  - [20] load (1) or store (0).
  - [19] base writeback.
  - [18] up (1) or down (0).
  - [17:16] reserved, ignored.
  - [15:0] register list.
- `base_i` in 32: first transfer address.
- `mem_ready_i` in 1: memory accepts or completes the current request.
- `mem_rdata_i` in 32: load data, valid when `mem_ready_i` is high.
- `reg_rdata_i` in 32: register-file read data for `reg_raddr_o` (asynchronous read).
- `remain_o` out 1: pipeline hold.
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: store request.
- `mem_addr_o` out 32: word address.
- `mem_wdata_o` out 32: equals `reg_rdata_i`.
- `reg_raddr_o` out 4: register currently being stored.
- `reg_we_o` out 1: load writeback strobe.
- `reg_waddr_o` out 4: load writeback register index.
- `reg_wdata_o` out 32: load writeback data.
- `base_we_o` out 1: base writeback strobe.
- `base_wdata_o` out 32: final base value.
- `done_o` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, XFER, WBACK.
- IDLE:
  - `cmd_valid_i` high with a nonzero list: latch list, load, wb, up and `addr <= base_i`, then go to XFER.
  - `cmd_valid_i` high with list == 0: no transfer and no writeback; `done_o` pulses the next cycle; stay in IDLE.
- XFER:
  - `mem_req_o` = 1, `mem_we_o` = !load, `mem_addr_o` = addr.
  - Current index: lowest set bit when up, highest set bit when down.
  - A transfer completes on a cycle with `mem_req_o` && `mem_ready_i`. On that cycle:
    - clear the current bit;
    - addr += 4 (up) or addr -= 4 (down), 32-bit wrap-around, no saturation;
    - for a load, capture `mem_rdata_i` and the index for writeback.
  - After the last bit: go to WBACK if wb is set, else go to IDLE with a `done_o` pulse.
- WBACK: lasts one cycle. `base_we_o` = 1, `base_wdata_o` = addr, i.e. base ± 4·popcount(list). Then go to IDLE with a `done_o` pulse.
- `remain_o` = (state != IDLE).
  - In the accepting cycle `remain_o` is 0, so the pipeline advances; the command has already been latched.
  - The next command is held in the pipeline until the sequencer returns to IDLE.
- `cmd_valid_i` is ignored outside IDLE.
- Stores: `reg_raddr_o` = current index, driven combinationally from the latched list. `mem_wdata_o` = `reg_rdata_i`.

## Timing
- Reset value of every output is 0. Reset forces IDLE and clears the list, addr and writeback registers. A reset mid-operation abandons the operation: no `done_o`, no `base_we_o`, and no pending `reg_we_o`.
- Accept edge to first `mem_req_o`: 1 cycle.
- With `mem_ready_i` held high, N transfers occupy N consecutive XFER cycles.
- `reg_we_o`, `reg_waddr_o` and `reg_wdata_o` are registered: `reg_we_o` is high one cycle after each completed load, for one cycle per transfer. The final writeback may coincide with WBACK or with the first IDLE cycle.
- When `mem_ready_i` is low, `mem_addr_o`, `mem_we_o` and `mem_wdata_o` are stable and the current bit is held.
- `done_o` is high in the first IDLE cycle after the operation. A new command may be accepted in that same cycle.
- Cycles with `remain_o` = 1, with ready always high: N + wb.

## Structure
- `lsm_pkg`:
  - state enum;
  - `cmd_i` field bit positions (LOAD=20, WB=19, UP=18, LIST=15:0);
  - `WORD_BYTES` = 4.
- Sub-module `lsm_prienc`: combinational find-first-set over 16 bits with a direction input (lowest or highest). It returns the 4-bit index and a valid flag. The sequencer instantiates it once.

## Test plan
- Store up: list 0x0005, base 0x1000, ready = 1, wb = 0.
  - Required: stores r0 @ 0x1000, then r2 @ 0x1004.
  - `remain_o` is high for 2 cycles; `done_o` pulses once; `base_we_o` stays 0.
- Load down with wb: list 0x8001, base 0x2000.
  - Required: loads r15 @ 0x2000, then r0 @ 0x1FFC.
  - `reg_we_o` pulses twice with the matching data.
  - `base_we_o` is high with 0x1FF8.
- Wait states: list 0x0002, `mem_ready_i` low for 3 cycles.
  - Required: request held stable for 4 cycles, addr unchanged.
  - `remain_o` is high for 4 cycles, then `done_o` pulses.
- Empty list with wb = 1.
  - Required: no `mem_req_o`, no `base_we_o`, `remain_o` stays 0, `done_o` pulses 1 cycle after accept.
- Back-to-back: second command present on the `done_o` cycle.
  - Required: the second command is accepted in that cycle and its first request follows 1 cycle later.
  - `cmd_valid_i` pulses during XFER are ignored.
- Reset mid-operation: assert `rst_i` during the 2nd of 4 transfers of list 0x000F.
  - Required: all outputs 0 immediately.
  - After release: IDLE, no `done_o`, no `base_we_o`.
- Wrap-around: base 0xFFFFFFFC, list 0x0003, up, wb = 1.
  - Required: addresses 0xFFFFFFFC then 0x00000000.
  - `base_wdata_o` = 0x00000004.

Source files
------------

// File: rtl/lsm_seq_pkg.sv
// Shared types and constants for the load/store-multiple sequencer.
// The command field positions match the LSM pipeline register layout.
package lsm_pkg;
  localparam int CMD_W      = 21;
  localparam int LIST_W     = 16;
  localparam int ADDR_W     = 32;
  localparam int IDX_W      = 4;
  localparam int WORD_BYTES = 4;

  localparam int CMD_LOAD    = 20;
  localparam int CMD_WB      = 19;
  localparam int CMD_UP      = 18;
  localparam int CMD_LIST_HI = 15;
  localparam int CMD_LIST_LO = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_WBACK = 2'd2
  } lsm_state_e;

  // Advance one word in the transfer direction; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                  input logic up);
    return up ? a + ADDR_W'(WORD_BYTES) : a - ADDR_W'(WORD_BYTES);
  endfunction
endpackage

// File: rtl/lsm_seq_if.sv
// Command, memory and register-file signals of the LSM sequencer.
// master = the sequencer, slave = pipeline/memory/register-file side.
interface lsm_seq_if;
  import lsm_pkg::*;

  logic              cmd_valid_i;
  logic [CMD_W-1:0]  cmd_i;
  logic [ADDR_W-1:0] base_i;
  logic              mem_ready_i;
  logic [ADDR_W-1:0] mem_rdata_i;
  logic [ADDR_W-1:0] reg_rdata_i;

  logic              remain_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [ADDR_W-1:0] mem_wdata_o;
  logic [IDX_W-1:0]  reg_raddr_o;
  logic              reg_we_o;
  logic [IDX_W-1:0]  reg_waddr_o;
  logic [ADDR_W-1:0] reg_wdata_o;
  logic              base_we_o;
  logic [ADDR_W-1:0] base_wdata_o;
  logic              done_o;

  modport master (
    input  cmd_valid_i, cmd_i, base_i, mem_ready_i, mem_rdata_i, reg_rdata_i,
    output remain_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, reg_raddr_o,
           reg_we_o, reg_waddr_o, reg_wdata_o, base_we_o, base_wdata_o, done_o
  );

  modport slave (
    output cmd_valid_i, cmd_i, base_i, mem_ready_i, mem_rdata_i, reg_rdata_i,
    input  remain_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, reg_raddr_o,
           reg_we_o, reg_waddr_o, reg_wdata_o, base_we_o, base_wdata_o, done_o
  );
endinterface

// File: rtl/lsm_seq_prienc.sv
// Find-first-set over the register list: lowest set bit when up,
// highest set bit when down.
module lsm_prienc
  import lsm_pkg::*;
(
  input  logic [LIST_W-1:0] vec,
  input  logic              up,
  output logic [IDX_W-1:0]  idx,
  output logic              vld
);
  always_comb begin
    idx = '0;
    vld = 1'b0;
    // Up: first hit sticks. Down: later hits overwrite, leaving the highest.
    for (int i = 0; i < LIST_W; i++) begin
      if (vec[i] && !(up && vld)) begin
        idx = IDX_W'(i);
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/lsm_seq.sv
// Load/store-multiple sequencer: expands a 16-bit register list into one
// word transfer per set bit, holding the pipeline while busy.
module lsm_seq
  import lsm_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  lsm_seq_if.master  bus
);
  lsm_state_e        state_q, state_d;
  logic [LIST_W-1:0] list_q, list_clr, cmd_list;
  logic              load_q, wb_q, up_q;
  logic [ADDR_W-1:0] addr_q;
  logic              done_q, done_d;
  logic              reg_we_q;
  logic [IDX_W-1:0]  reg_waddr_q;
  logic [ADDR_W-1:0] reg_wdata_q;
  logic [IDX_W-1:0]  cur_idx;
  logic              cur_vld, fire, accept, store_act;

  assign cmd_list = bus.cmd_i[CMD_LIST_HI:CMD_LIST_LO];

  lsm_prienc u_prienc (
    .vec (list_q),
    .up  (up_q),
    .idx (cur_idx),
    .vld (cur_vld)
  );

  assign fire      = (state_q == S_XFER) && cur_vld && bus.mem_ready_i;
  assign accept    = (state_q == S_IDLE) && bus.cmd_valid_i && (cmd_list != '0);
  assign list_clr  = list_q & ~(LIST_W'(1) << cur_idx);
  assign store_act = (state_q == S_XFER) && !load_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // An empty list completes immediately, with no writeback even if requested.
        if (bus.cmd_valid_i) begin
          if (cmd_list != '0) state_d = S_XFER;
          else                done_d  = 1'b1;
        end
      end
      S_XFER: begin
        if (fire && (list_clr == '0)) begin
          if (wb_q) begin
            state_d = S_WBACK;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_WBACK: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.remain_o     = (state_q != S_IDLE);
    bus.mem_req_o    = (state_q == S_XFER);
    bus.mem_we_o     = store_act;
    bus.mem_addr_o   = (state_q == S_XFER) ? addr_q : '0;
    bus.mem_wdata_o  = store_act ? bus.reg_rdata_i : '0;
    bus.reg_raddr_o  = cur_idx;
    bus.reg_we_o     = reg_we_q;
    bus.reg_waddr_o  = reg_waddr_q;
    bus.reg_wdata_o  = reg_wdata_q;
    bus.base_we_o    = (state_q == S_WBACK);
    bus.base_wdata_o = (state_q == S_WBACK) ? addr_q : '0;
    bus.done_o       = done_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      list_q      <= '0;
      load_q      <= 1'b0;
      wb_q        <= 1'b0;
      up_q        <= 1'b0;
      addr_q      <= '0;
      done_q      <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
    end else begin
      done_q   <= done_d;
      reg_we_q <= fire && load_q;
      if (fire && load_q) begin
        reg_waddr_q <= cur_idx;
        reg_wdata_q <= bus.mem_rdata_i;
      end
      if (accept) begin
        list_q <= cmd_list;
        load_q <= bus.cmd_i[CMD_LOAD];
        wb_q   <= bus.cmd_i[CMD_WB];
        up_q   <= bus.cmd_i[CMD_UP];
        addr_q <= bus.base_i;
      end else if (fire) begin
        list_q <= list_clr;
        addr_q <= step_addr(addr_q, up_q);
      end
    end
  end
endmodule
